// File: rtl/beat_sequencer.sv
// rtl/beat_sequencer.sv - play/pause/stop transport controller producing the beat index and play enable
module beat_sequencer #(
    parameter int BASE_DIV = 25_000_000,
    parameter int BEAT_LEN = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        play_pause,
    input  logic        stop,
    input  logic        loop_en,
    input  logic [1:0]  tempo_sel,
    output logic [11:0] ibeatNum,
    output logic        en,
    output logic        beat_pulse,
    output logic        done,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    localparam logic [31:0] BASE      = 32'(BASE_DIV);
    localparam logic [11:0] LAST_BEAT = 12'(BEAT_LEN - 1);

    state_t      state_q, state_d;
    logic [11:0] beat_q, beat_d;
    logic [31:0] tick_q, tick_d;
    logic [31:0] period_q, period_d;
    logic        en_q, en_d;
    logic        pulse_q, pulse_d;
    logic        done_q, done_d;
    logic        boundary;

    // Last tick of the current beat; only meaningful while playing.
    assign boundary = (state_q == S_PLAY) && (tick_q == period_q - 32'd1);

    // State register plus every registered output; reset is asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            beat_q   <= 12'd0;
            tick_q   <= 32'd0;
            period_q <= BASE;
            en_q     <= 1'b0;
            pulse_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            tick_q   <= tick_d;
            period_q <= period_d;
            en_q     <= en_d;
            pulse_q  <= pulse_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: stop first, then per-state transport and beat counting.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        tick_d   = tick_q;
        period_d = period_q;
        pulse_d  = 1'b0;
        done_d   = 1'b0;

        if (stop) begin
            state_d = S_IDLE;
            beat_d  = 12'd0;
            tick_d  = 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (play_pause) begin
                        state_d  = S_PLAY;
                        beat_d   = 12'd0;
                        tick_d   = 32'd0;
                        period_d = BASE >> tempo_sel;
                    end
                end
                S_PLAY: begin
                    if (boundary) begin
                        // Tempo only reloads here so a running beat is never cut short.
                        tick_d   = 32'd0;
                        pulse_d  = 1'b1;
                        period_d = BASE >> tempo_sel;
                        if (beat_q == LAST_BEAT) begin
                            beat_d = 12'd0;
                            if (!loop_en) begin
                                // End of a one-shot song overrides a simultaneous pause.
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end else if (play_pause) begin
                                state_d = S_PAUSE;
                            end
                        end else begin
                            beat_d = beat_q + 12'd1;
                            if (play_pause) begin
                                state_d = S_PAUSE;
                            end
                        end
                    end else if (play_pause) begin
                        // Pausing freezes tick_cnt where it stands so resume continues the beat.
                        state_d = S_PAUSE;
                    end else begin
                        tick_d = tick_q + 32'd1;
                    end
                end
                S_PAUSE: begin
                    if (play_pause) begin
                        state_d = S_PLAY;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    beat_d  = 12'd0;
                    tick_d  = 32'd0;
                end
            endcase
        end

        en_d = (state_d == S_PLAY);
    end

    assign ibeatNum   = beat_q;
    assign en         = en_q;
    assign beat_pulse = pulse_q;
    assign done       = done_q;
    assign state      = state_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// tb/tb_beat_sequencer.sv - directed vector bench for beat_sequencer
module tb_beat_sequencer;

    logic        clk;
    logic        rst_n;
    logic        play_pause;
    logic        stop;
    logic        loop_en;
    logic [1:0]  tempo_sel;
    logic [11:0] ibeatNum;
    logic        en;
    logic        beat_pulse;
    logic        done;
    logic [1:0]  state;

    int tests;
    int fails;

    beat_sequencer #(
        .BASE_DIV (8),
        .BEAT_LEN (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .play_pause (play_pause),
        .stop       (stop),
        .loop_en    (loop_en),
        .tempo_sel  (tempo_sel),
        .ibeatNum   (ibeatNum),
        .en         (en),
        .beat_pulse (beat_pulse),
        .done       (done),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pp;
        logic        stp;
        logic        lp;
        logic [1:0]  tmp;
        int          n;
        logic [1:0]  st;
        logic [11:0] bt;
        logic        en;
        logic        bp;
        logic        dn;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic [11:0] bt,
                           input logic e, input logic bp, input logic dn);
        chk({tag, "_state"}, 32'(state), 32'(st));
        chk({tag, "_beat"}, 32'(ibeatNum), 32'(bt));
        chk({tag, "_en"}, 32'(en), 32'(e));
        chk({tag, "_pulse"}, 32'(beat_pulse), 32'(bp));
        chk({tag, "_done"}, 32'(done), 32'(dn));
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_pp();
        play_pause = 1'b1;
        step(1);
        play_pause = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        rst_n      = 1'b0;
        play_pause = 1'b0;
        stop       = 1'b0;
        loop_en    = 1'b1;
        tempo_sel  = 2'd0;

        //            pp stp lp tmp  n   st    beat   en bp dn
        vecs[0]  = '{1, 0, 1, 2'd0, 1,  2'd1, 12'd0, 1, 0, 0};
        vecs[1]  = '{0, 0, 1, 2'd0, 7,  2'd1, 12'd0, 1, 0, 0};
        vecs[2]  = '{0, 0, 1, 2'd0, 1,  2'd1, 12'd1, 1, 1, 0};
        vecs[3]  = '{0, 0, 1, 2'd0, 1,  2'd1, 12'd1, 1, 0, 0};
        vecs[4]  = '{0, 0, 1, 2'd0, 7,  2'd1, 12'd2, 1, 1, 0};
        vecs[5]  = '{0, 0, 1, 2'd0, 8,  2'd1, 12'd3, 1, 1, 0};
        vecs[6]  = '{0, 0, 1, 2'd0, 8,  2'd1, 12'd0, 1, 1, 0};
        vecs[7]  = '{0, 0, 0, 2'd0, 24, 2'd1, 12'd3, 1, 1, 0};
        vecs[8]  = '{0, 0, 0, 2'd0, 8,  2'd0, 12'd0, 0, 1, 1};
        vecs[9]  = '{0, 0, 0, 2'd0, 1,  2'd0, 12'd0, 0, 0, 0};
        vecs[10] = '{1, 0, 1, 2'd0, 1,  2'd1, 12'd0, 1, 0, 0};
        vecs[11] = '{0, 0, 1, 2'd0, 3,  2'd1, 12'd0, 1, 0, 0};
        vecs[12] = '{1, 1, 1, 2'd0, 1,  2'd0, 12'd0, 0, 0, 0};
        vecs[13] = '{0, 0, 1, 2'd0, 5,  2'd0, 12'd0, 0, 0, 0};
        vecs[14] = '{1, 0, 1, 2'd0, 1,  2'd1, 12'd0, 1, 0, 0};
        vecs[15] = '{0, 0, 1, 2'd0, 10, 2'd1, 12'd1, 1, 0, 0};
        vecs[16] = '{1, 0, 1, 2'd0, 1,  2'd2, 12'd1, 0, 0, 0};
        vecs[17] = '{0, 0, 1, 2'd0, 20, 2'd2, 12'd1, 0, 0, 0};
        vecs[18] = '{1, 0, 1, 2'd0, 1,  2'd1, 12'd1, 1, 0, 0};
        vecs[19] = '{0, 0, 1, 2'd0, 5,  2'd1, 12'd1, 1, 0, 0};
        vecs[20] = '{0, 0, 1, 2'd0, 1,  2'd1, 12'd2, 1, 1, 0};
        vecs[21] = '{0, 1, 1, 2'd0, 1,  2'd0, 12'd0, 0, 0, 0};

        // Reset state
        #23;
        chk_all("reset", 2'd0, 12'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Table-driven vectors: pulses only on the first of n cycles
        for (int i = 0; i < 22; i++) begin
            play_pause = vecs[i].pp;
            stop       = vecs[i].stp;
            loop_en    = vecs[i].lp;
            tempo_sel  = vecs[i].tmp;
            step(1);
            play_pause = 1'b0;
            stop       = 1'b0;
            step(vecs[i].n - 1);
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].bt, vecs[i].en, vecs[i].bp, vecs[i].dn);
        end

        // Pause at tick 5 of beat 2, hold 20 cycles, resume: beat 3 exactly 3 cycles later
        loop_en   = 1'b1;
        tempo_sel = 2'd0;
        pulse_pp();
        step(16);
        chk("pause_at_beat2", 32'(ibeatNum), 32'd2);
        step(5);
        pulse_pp();
        chk_all("pause_enter", 2'd2, 12'd2, 1'b0, 1'b0, 1'b0);
        step(20);
        chk_all("pause_hold", 2'd2, 12'd2, 1'b0, 1'b0, 1'b0);
        pulse_pp();
        chk_all("pause_resume", 2'd1, 12'd2, 1'b1, 1'b0, 1'b0);
        step(2);
        chk_all("resume_plus2", 2'd1, 12'd2, 1'b1, 1'b0, 1'b0);
        step(1);
        chk_all("resume_plus3", 2'd1, 12'd3, 1'b1, 1'b1, 1'b0);
        pulse_stop();

        // Tempo change 0->2 at tick 3 of beat 1: beat 1 stays 8 cycles, later beats 2 cycles
        pulse_pp();
        step(8);
        chk("tempo_beat1", 32'(ibeatNum), 32'd1);
        step(3);
        tempo_sel = 2'd2;
        step(4);
        chk_all("tempo_beat1_tick7", 2'd1, 12'd1, 1'b1, 1'b0, 1'b0);
        step(1);
        chk_all("tempo_beat2", 2'd1, 12'd2, 1'b1, 1'b1, 1'b0);
        step(1);
        chk_all("tempo_beat2_mid", 2'd1, 12'd2, 1'b1, 1'b0, 1'b0);
        step(1);
        chk_all("tempo_beat3", 2'd1, 12'd3, 1'b1, 1'b1, 1'b0);
        step(2);
        chk_all("tempo_wrap", 2'd1, 12'd0, 1'b1, 1'b1, 1'b0);
        tempo_sel = 2'd0;
        pulse_stop();

        // play_pause on a non-final boundary: advance and pause together
        pulse_pp();
        step(7);
        pulse_pp();
        chk_all("pp_on_boundary", 2'd2, 12'd1, 1'b0, 1'b1, 1'b0);
        step(3);
        chk_all("pp_on_boundary_hold", 2'd2, 12'd1, 1'b0, 1'b0, 1'b0);
        pulse_stop();

        // play_pause on a one-shot final boundary: song end wins
        loop_en = 1'b0;
        pulse_pp();
        step(31);
        chk_all("oneshot_last_tick", 2'd1, 12'd3, 1'b1, 1'b0, 1'b0);
        pulse_pp();
        chk_all("oneshot_pp_end", 2'd0, 12'd0, 1'b0, 1'b1, 1'b1);
        step(1);
        chk_all("oneshot_after", 2'd0, 12'd0, 1'b0, 1'b0, 1'b0);
        loop_en = 1'b1;

        // Asynchronous reset mid-beat, then restart from beat 0
        pulse_pp();
        step(10);
        chk("prereset_beat", 32'(ibeatNum), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 2'd0, 12'd0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        step(1);
        chk("post_reset_idle", 32'(state), 32'd0);
        pulse_pp();
        chk_all("restart", 2'd1, 12'd0, 1'b1, 1'b0, 1'b0);
        step(7);
        chk("restart_tick7", 32'(ibeatNum), 32'd0);
        step(1);
        chk_all("restart_beat1", 2'd1, 12'd1, 1'b1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
